instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-low reset (Rst=0 resets).
REQ-004 Stall  input  1  hazard-unit hold; IF/ID register and PC frozen.
REQ-005 Branch  input  1  taken-branch redirect from later stage.
REQ-006 BranchTarget  input  32  branch destination address.
REQ-007 Jump  input  1  jump redirect from decode.
REQ-008 JumpIndex  input  26  instr_index field of the jump.
REQ-009 IMemReq  output  1  instruction-memory read request.
REQ-010 IMemAddr  output  32  word address presented to instruction memory.
REQ-011 IMemReady  input  1  IMemData valid this cycle for IMemAddr.
REQ-012 IMemData  input  32  fetched instruction word.
REQ-013 Instruction  output  32  IF/ID instruction, feeds the main controller.
REQ-014 PCPlus4  output  32  IF/ID PC+4 of Instruction.
REQ-015 IFIDValid  output  1  Instruction is a real fetched instruction.

Function
REQ-016 The block SHALL hold a 32-bit PC register; IMemAddr SHALL equal {PC[31:2],2'b00} combinationally.
REQ-017 The block SHALL implement a two-state FSM: FETCH (IMemReq=1) and HOLD (IMemReq=0, fetched word kept in a 32-bit skid buffer).
REQ-018 FETCH, IMemReady=1, Stall=0: IF/ID <= {IMemData, PC+4, valid=1}; PC <= PC+4; stay FETCH.
REQ-019 FETCH, IMemReady=1, Stall=1: skid buffer <= IMemData; IF/ID and PC unchanged; go HOLD.
REQ-020 FETCH, IMemReady=0, Stall=0: IF/ID <= bubble (Instruction=32'h0, valid=0, PCPlus4 unchanged); PC unchanged.
REQ-021 FETCH, IMemReady=0, Stall=1: IF/ID and PC unchanged.
REQ-022 HOLD, Stall=1: all state unchanged; HOLD, Stall=0: IF/ID <= {buffer, PC+4, valid=1}; PC <= PC+4; go FETCH.
REQ-023 Redirect = Branch | Jump; Branch SHALL take priority over Jump when both asserted.
REQ-024 Branch target SHALL be {BranchTarget[31:2],2'b00}; jump target SHALL be {PCPlus4[31:28], JumpIndex, 2'b00} using the current IF/ID PCPlus4.
REQ-025 On a redirect edge, regardless of Stall, state or IMemReady: PC <= target; IF/ID <= bubble; skid buffer discarded; next state FETCH.
REQ-026 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000) with no error indication.
REQ-027 Fetch-to-IF/ID latency SHALL be exactly one edge after the IMemReady cycle when not stalled.
REQ-028 An instruction SHALL never be duplicated or dropped across any Stall pattern absent a redirect.

Reset
REQ-029 While Rst=0, asynchronously: PC=RESET_PC, state=FETCH, Instruction=32'h0, PCPlus4=32'h0, IFIDValid=0, skid buffer=32'h0.
REQ-030 IMemReq SHALL be 0 while Rst=0 and 1 from the first edge after Rst rises.
REQ-031 Reset asserted mid-HOLD or mid-redirect SHALL override all inputs immediately.

Verification
REQ-032 Reset, IMemReady=1, IMemData=32'h0022_1820 -> IMemAddr 0,4,8 on successive cycles; Instruction=32'h0022_1820, PCPlus4=4 then 8, IFIDValid=1.
REQ-033 Stall high 3 cycles while IMemReady=1 at PC=8 -> HOLD entered, IMemReq=0, IF/ID frozen; on release word at 8 appears once with PCPlus4=12.
REQ-034 IMemReady low 2 cycles at PC=16 -> two bubbles (Instruction=0, IFIDValid=0), PC stays 16, then normal fetch.
REQ-035 Branch=1, BranchTarget=32'h0000_0043 with Jump=1 and Stall=1 same cycle -> PC=32'h40, IFIDValid=0 next cycle, skid buffer discarded.
REQ-036 Jump=1, JumpIndex=26'h000_0010, PCPlus4=32'h1000_0008 -> next IMemAddr=32'h1000_0040, one bubble.
REQ-037 RESET_PC=32'hFFFF_FFFC, IMemReady=1 -> second fetch address 32'h0000_0000, PCPlus4=0 for first word.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, FETCH/HOLD fetch FSM with a one-word skid
// buffer, branch/jump redirect, and the IF/ID pipeline register.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        IFIDValid
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  state_t      state, state_nxt;
  ifid_t       ifid, ifid_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] skid, skid_nxt;
  logic        started;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        unused_bits;

  // Alignment bits of the branch target are dropped on purpose.
  assign unused_bits = ^BranchTarget[1:0];

  assign pc_inc   = pc + 32'd4;
  assign redirect = Branch | Jump;
  assign target   = Branch ? {BranchTarget[31:2], 2'b00}
                           : {ifid.pc_plus4[31:28], JumpIndex, 2'b00};

  // Request is held low until the first edge after reset release.
  assign IMemReq     = started && (state == FETCH);
  assign IMemAddr    = {pc[31:2], 2'b00};
  assign Instruction = ifid.instr;
  assign PCPlus4     = ifid.pc_plus4;
  assign IFIDValid   = ifid.valid;

  always_comb begin
    state_nxt = state;
    ifid_nxt  = ifid;
    pc_nxt    = pc;
    skid_nxt  = skid;
    if (redirect) begin
      pc_nxt         = target;
      ifid_nxt.instr = 32'h0;
      ifid_nxt.valid = 1'b0;
      skid_nxt       = 32'h0;
      state_nxt      = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (IMemReq && IMemReady) begin
            if (!Stall) begin
              ifid_nxt = '{instr: IMemData, pc_plus4: pc_inc, valid: 1'b1};
              pc_nxt   = pc_inc;
            end else begin
              skid_nxt  = IMemData;
              state_nxt = HOLD;
            end
          end else if (!Stall) begin
            ifid_nxt.instr = 32'h0;
            ifid_nxt.valid = 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifid_nxt  = '{instr: skid, pc_plus4: pc_inc, valid: 1'b1};
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= FETCH;
      ifid    <= '0;
      pc      <= RESET_PC;
      skid    <= 32'h0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      ifid    <= ifid_nxt;
      pc      <= pc_nxt;
      skid    <= skid_nxt;
      started <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: reset, sequential fetch, stall/HOLD,
// memory bubbles, branch/jump redirect, PC wrap and asynchronous reset mid-HOLD.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall, Branch, Jump, IMemReady;
  logic [31:0] BranchTarget, IMemData;
  logic [25:0] JumpIndex;
  logic        IMemReq, IFIDValid;
  logic [31:0] IMemAddr, Instruction, PCPlus4;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pcp4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  instruction_fetch_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Branch(Branch), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpIndex(JumpIndex), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemData(IMemData), .Instruction(Instruction),
    .PCPlus4(PCPlus4), .IFIDValid(IFIDValid)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Branch(Branch), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpIndex(JumpIndex), .IMemReq(w_req), .IMemAddr(w_addr),
    .IMemReady(IMemReady), .IMemData(IMemData), .Instruction(w_instr),
    .PCPlus4(w_pcp4), .IFIDValid(w_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full IF/ID + fetch-port snapshot of the main instance.
  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] instr, input logic [31:0] pcp4, input logic vld);
    chk({tag, ".req"},   {31'h0, IMemReq},   {31'h0, req});
    chk({tag, ".addr"},  IMemAddr,           addr);
    chk({tag, ".instr"}, Instruction,        instr);
    chk({tag, ".pcp4"},  PCPlus4,            pcp4);
    chk({tag, ".valid"}, {31'h0, IFIDValid}, {31'h0, vld});
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0;
    BranchTarget = 32'h0; JumpIndex = 26'h0;
    IMemReady = 1'b1; IMemData = 32'h0022_1820;

    // Reset state, with an edge passing while reset is held
    @(posedge Clk); #1;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.wrap_addr", w_addr, 32'hFFFF_FFFC);
    Rst = 1'b1;
    #1;
    chk("rel.req_before_edge", {31'h0, IMemReq}, 32'h0);

    step();
    chk_all("start", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("start.wrap_addr", w_addr, 32'hFFFF_FFFC);

    // Sequential fetch 0,4,8
    step();
    chk_all("fetch0", 1'b1, 32'h4, 32'h0022_1820, 32'h4, 1'b1);
    chk("wrap.addr", w_addr, 32'h0);
    chk("wrap.pcp4", w_pcp4, 32'h0);
    chk("wrap.valid", {31'h0, w_valid}, 32'h1);
    step();
    chk_all("fetch4", 1'b1, 32'h8, 32'h0022_1820, 32'h8, 1'b1);

    // Stall 3 cycles at PC=8 with the memory ready
    Stall = 1'b1; IMemData = 32'hAAAA_0008;
    step();
    chk_all("hold1", 1'b0, 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    IMemData = 32'hDEAD_BEEF;
    step();
    chk_all("hold2", 1'b0, 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    step();
    chk_all("hold3", 1'b0, 32'h8, 32'h0022_1820, 32'h8, 1'b1);
    Stall = 1'b0;
    step();
    chk_all("release", 1'b1, 32'hC, 32'hAAAA_0008, 32'hC, 1'b1);
    IMemData = 32'h0000_000C;
    step();
    chk_all("after_release", 1'b1, 32'h10, 32'h0000_000C, 32'h10, 1'b1);

    // Memory not ready 2 cycles at PC=16
    IMemReady = 1'b0;
    step();
    chk_all("bubble1", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    step();
    chk_all("bubble2", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    IMemReady = 1'b1; IMemData = 32'h0000_0010;
    step();
    chk_all("resume", 1'b1, 32'h14, 32'h0000_0010, 32'h14, 1'b1);

    // Enter HOLD, then branch+jump under stall: branch wins, skid discarded
    Stall = 1'b1; IMemData = 32'h0000_0014;
    step();
    chk("pre_branch.req", {31'h0, IMemReq}, 32'h0);
    Branch = 1'b1; BranchTarget = 32'h0000_0043; Jump = 1'b1; JumpIndex = 26'h3FF_FFFF;
    step();
    chk_all("branch", 1'b1, 32'h40, 32'h0, 32'h14, 1'b0);
    Branch = 1'b0; Jump = 1'b0; Stall = 1'b0; IMemData = 32'h0000_0040;
    step();
    chk_all("post_branch", 1'b1, 32'h44, 32'h0000_0040, 32'h44, 1'b1);

    // Get PCPlus4=0x1000_0008, then jump
    Branch = 1'b1; BranchTarget = 32'h1000_0004;
    step();
    chk_all("branch2", 1'b1, 32'h1000_0004, 32'h0, 32'h44, 1'b0);
    Branch = 1'b0; IMemData = 32'h0800_0010;
    step();
    chk_all("pre_jump", 1'b1, 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 1'b1);
    Jump = 1'b1; JumpIndex = 26'h000_0010;
    step();
    chk_all("jump", 1'b1, 32'h1000_0040, 32'h0, 32'h1000_0008, 1'b0);
    Jump = 1'b0; IMemData = 32'h0000_0055;
    step();
    chk_all("post_jump", 1'b1, 32'h1000_0044, 32'h0000_0055, 32'h1000_0044, 1'b1);

    // Stall while memory not ready: everything frozen
    Stall = 1'b1; IMemReady = 1'b0;
    step();
    chk_all("stall_nready", 1'b1, 32'h1000_0044, 32'h0000_0055, 32'h1000_0044, 1'b1);

    // Enter HOLD then assert reset mid-cycle
    IMemReady = 1'b1; IMemData = 32'h0000_0077;
    step();
    chk("hold_again.req", {31'h0, IMemReq}, 32'h0);
    #2 Rst = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    Stall = 1'b0; IMemData = 32'h0000_0099;
    #1 Rst = 1'b1;
    step();
    chk_all("rst2_start", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_all("rst2_fetch", 1'b1, 32'h4, 32'h0000_0099, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
